lsu_sequencer: RTL and testbench

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

---
 rtl/lsu_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: turns one RV32I load/store request into byte or word memory beats and returns an extended result.
// Optional build macro LSU_MISALIGNED_SPLIT_EN executes misaligned accesses as byte beats instead of rejecting them.
module lsu_sequencer #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err_misaligned,
  output logic        err_range,
  output logic        err_illegal,
  output logic        mem_size,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state, state_d;
  logic [1:0]  beat_cnt, beat_cnt_d, last_beat, last_beat_d;
  logic        word_mode, word_mode_d, op_write, op_write_d;
  logic [2:0]  op_funct3, op_funct3_d;
  logic [31:0] op_addr, op_addr_d, op_wdata, op_wdata_d, asm_q, asm_d, asm_cap;
  logic [31:0] rdata_d, mem_addr_d, mem_wdata_d;
  logic        resp_valid_d, err_mis_d, err_rng_d, err_ill_d;
  logic        mem_size_d, mem_read_d, mem_write_d;

  // Request decode, evaluated on the live request inputs in IDLE
  logic        is_half, is_word, illegal, misaligned, mis_err, range_err, plan_word;
  logic [2:0]  nbytes;
  logic [1:0]  plan_last;
  logic [32:0] end_addr;

  assign is_half    = (funct3[1:0] == 2'b01);
  assign is_word    = (funct3[1:0] == 2'b10);
  assign illegal    = req_write ? (funct3[2] || funct3[1:0] == 2'b11)
                                : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
  assign nbytes     = is_word ? 3'd4 : (is_half ? 3'd2 : 3'd1);
  assign end_addr   = {1'b0, addr} + {30'b0, nbytes} - 33'd1;
  assign range_err  = (end_addr >= 33'(ADDR_LIMIT));
  assign misaligned = (is_half && addr[0]) || (is_word && addr[1:0] != 2'b00);
  assign plan_word  = is_word && !misaligned;
  assign plan_last  = is_word ? (misaligned ? 2'd3 : 2'd0) : (is_half ? 2'd1 : 2'd0);

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign mis_err = 1'b0;
`else
  assign mis_err = misaligned;
`endif

  assign req_ready = (state == S_IDLE);

  // Load assembly with the beat currently on the bus merged in
  assign asm_cap = word_mode ? mem_rdata
                             : (asm_q | (32'(mem_rdata[7:0]) << {beat_cnt, 3'b000}));

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  load_ext = {{24{a[7]}}, a[7:0]};
      3'b001:  load_ext = {{16{a[15]}}, a[15:0]};
      3'b100:  load_ext = {24'b0, a[7:0]};
      3'b101:  load_ext = {16'b0, a[15:0]};
      default: load_ext = a;
    endcase
  endfunction

  logic        issue, iss_word, iss_write;
  logic [1:0]  iss_k;
  logic [31:0] iss_addr, iss_wdata, iss_wsh;

  assign iss_wsh = iss_wdata >> {iss_k, 3'b000};

  always_comb begin
    state_d      = state;
    beat_cnt_d   = beat_cnt;
    last_beat_d  = last_beat;
    word_mode_d  = word_mode;
    op_write_d   = op_write;
    op_funct3_d  = op_funct3;
    op_addr_d    = op_addr;
    op_wdata_d   = op_wdata;
    asm_d        = asm_q;
    rdata_d      = '0;
    resp_valid_d = 1'b0;
    err_mis_d    = 1'b0;
    err_rng_d    = 1'b0;
    err_ill_d    = 1'b0;
    mem_size_d   = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    issue        = 1'b0;
    iss_k        = beat_cnt + 2'd1;
    iss_addr     = op_addr;
    iss_wdata    = op_wdata;
    iss_word     = word_mode;
    iss_write    = op_write;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          op_write_d  = req_write;
          op_funct3_d = funct3;
          op_addr_d   = addr;
          op_wdata_d  = wdata;
          beat_cnt_d  = 2'd0;
          asm_d       = '0;
          if (illegal || range_err || mis_err) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            err_ill_d    = illegal;
            err_rng_d    = !illegal && range_err;
            err_mis_d    = !illegal && !range_err && mis_err;
          end else begin
            state_d     = S_BUSY;
            last_beat_d = plan_last;
            word_mode_d = plan_word;
            issue       = 1'b1;
            iss_k       = 2'd0;
            iss_addr    = addr;
            iss_wdata   = wdata;
            iss_word    = plan_word;
            iss_write   = req_write;
          end
        end
      end
      S_BUSY: begin
        asm_d = asm_cap;
        if (beat_cnt == last_beat) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          rdata_d      = op_write ? 32'b0 : load_ext(op_funct3, asm_cap);
        end else begin
          beat_cnt_d = beat_cnt + 2'd1;
          issue      = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      mem_read_d  = !iss_write;
      mem_write_d = iss_write;
      mem_size_d  = iss_word;
      mem_addr_d  = iss_word ? iss_addr : iss_addr + 32'(iss_k);
      mem_wdata_d = iss_word ? iss_wdata : {24'b0, iss_wsh[7:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      beat_cnt       <= '0;
      last_beat      <= '0;
      word_mode      <= 1'b0;
      op_write       <= 1'b0;
      op_funct3      <= '0;
      op_addr        <= '0;
      op_wdata       <= '0;
      asm_q          <= '0;
      rdata          <= '0;
      resp_valid     <= 1'b0;
      err_misaligned <= 1'b0;
      err_range      <= 1'b0;
      err_illegal    <= 1'b0;
      mem_size       <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      state          <= state_d;
      beat_cnt       <= beat_cnt_d;
      last_beat      <= last_beat_d;
      word_mode      <= word_mode_d;
      op_write       <= op_write_d;
      op_funct3      <= op_funct3_d;
      op_addr        <= op_addr_d;
      op_wdata       <= op_wdata_d;
      asm_q          <= asm_d;
      rdata          <= rdata_d;
      resp_valid     <= resp_valid_d;
      err_misaligned <= err_mis_d;
      err_range      <= err_rng_d;
      err_illegal    <= err_ill_d;
      mem_size       <= mem_size_d;
      mem_read       <= mem_read_d;
      mem_write      <= mem_write_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer with a byte-array memory model and an expected-response queue.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        req_ready, resp_valid, err_misaligned, err_range, err_illegal;
  logic [31:0] rdata;
  logic        mem_size, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_sequencer #(.ADDR_LIMIT(1024)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .err_misaligned(err_misaligned),
    .err_range(err_range), .err_illegal(err_illegal), .mem_size(mem_size),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, write on the edge ending a beat
  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  logic [31:0] wr_log [$];
  int          strobes = 0;
  int          overlap = 0;

  always_comb begin
    if (mem_size)
      mem_rdata = {mem[10'(mem_addr + 32'd3)], mem[10'(mem_addr + 32'd2)],
                   mem[10'(mem_addr + 32'd1)], mem[mem_addr[9:0]]};
    else
      mem_rdata = {24'b0, mem[mem_addr[9:0]]};
  end

  always @(posedge clk) begin
    if (mem_read && mem_write) overlap <= overlap + 1;
    if (mem_read || mem_write) strobes <= strobes + 1;
    if (mem_write) begin
      wr_log.push_back({mem_addr[23:0], mem_wdata[7:0]});
      if (mem_size) begin
        for (int k = 0; k < 4; k++) mem[10'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
      end else begin
        mem[mem_addr[9:0]] <= mem_wdata[7:0];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  err;
    int          lat;
  } exp_t;
  exp_t sb [$];

  localparam logic [2:0] E_NONE = 3'b000, E_ILL = 3'b100, E_RNG = 3'b010, E_MIS = 3'b001;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic [2:0] exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    logic got;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".ready_after_accept"}, 32'(req_ready), 32'd0);
    lat = 1; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (resp_valid) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    chk({tag, ".resp_seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      chk({tag, ".rdata"}, rdata, e.rdata);
      chk({tag, ".err"}, 32'({err_illegal, err_range, err_misaligned}), 32'(e.err));
      chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
      chk({tag, ".mem_idle_in_done"}, 32'({mem_read, mem_write}) | mem_addr | mem_wdata, 32'd0);
      @(posedge clk); #1;
      chk({tag, ".resp_one_cycle"}, 32'({resp_valid, err_illegal, err_range, err_misaligned}) | rdata, 32'd0);
    end
  endtask

  int s0;

  initial begin
    // Reset state
    #2;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp", 32'({resp_valid, err_illegal, err_range, err_misaligned}) | rdata, 32'd0);
    chk("rst.mem", 32'({mem_read, mem_write, mem_size}) | mem_addr | mem_wdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_req("sw0",  1'b1, 3'b010, 32'd0, 32'h0001_0000, 32'h0, E_NONE, 2);
    chk("mem2", 32'(mem[2]), 32'h01);
    run_req("lw0",  1'b0, 3'b010, 32'd0, 32'h0, 32'h0001_0000, E_NONE, 2);

    run_req("sb5",  1'b1, 3'b000, 32'd5, 32'hFFFF_FF8A, 32'h0, E_NONE, 2);
    run_req("lb5",  1'b0, 3'b000, 32'd5, 32'h0, 32'hFFFF_FF8A, E_NONE, 2);
    run_req("lbu5", 1'b0, 3'b100, 32'd5, 32'h0, 32'h0000_008A, E_NONE, 2);

    wr_log.delete();
    run_req("sh6",  1'b1, 3'b001, 32'd6, 32'h1234_ABCD, 32'h0, E_NONE, 3);
    chk("sh6.nwrites", 32'(wr_log.size()), 32'd2);
    chk("sh6.beat0", wr_log[0], 32'h0000_06CD);
    chk("sh6.beat1", wr_log[1], 32'h0000_07AB);
    run_req("lhu6", 1'b0, 3'b101, 32'd6, 32'h0, 32'h0000_ABCD, E_NONE, 3);
    run_req("lh6",  1'b0, 3'b001, 32'd6, 32'h0, 32'hFFFF_ABCD, E_NONE, 3);

    s0 = strobes;
    run_req("lw1021",   1'b0, 3'b010, 32'd1021, 32'h0, 32'h0, E_RNG, 1);
    run_req("ld_f011",  1'b0, 3'b011, 32'd0, 32'h0, 32'h0, E_ILL, 1);
    run_req("st_f100",  1'b1, 3'b100, 32'd0, 32'h0, 32'h0, E_ILL, 1);
    run_req("ill_rng",  1'b0, 3'b011, 32'd1021, 32'h0, 32'h0, E_ILL, 1);
    run_req("rng_mis",  1'b0, 3'b010, 32'd1022, 32'h0, 32'h0, E_RNG, 1);
    run_req("wrap",     1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, E_RNG, 1);
    chk("err.no_strobe", 32'(strobes - s0), 32'd0);

    run_req("lw1020", 1'b0, 3'b010, 32'd1020, 32'h0, 32'h0, E_NONE, 2);
    run_req("sb1023", 1'b1, 3'b000, 32'd1023, 32'h0000_0077, 32'h0, E_NONE, 2);
    chk("mem1023", 32'(mem[1023]), 32'h77);

    // Bytes [2..5] = 11,22,33,44
    run_req("sh2", 1'b1, 3'b001, 32'd2, 32'h0000_2211, 32'h0, E_NONE, 3);
    run_req("sw4", 1'b1, 3'b010, 32'd4, 32'h0000_4433, 32'h0, E_NONE, 2);
    s0 = strobes;
`ifdef LSU_MISALIGNED_SPLIT_EN
    run_req("lw2", 1'b0, 3'b010, 32'd2, 32'h0, 32'h4433_2211, E_NONE, 5);
    chk("lw2.strobes", 32'(strobes - s0), 32'd4);
    run_req("lh3", 1'b0, 3'b001, 32'd3, 32'h0, 32'h0000_3322, E_NONE, 3);
`else
    run_req("lw2", 1'b0, 3'b010, 32'd2, 32'h0, 32'h0, E_MIS, 1);
    chk("lw2.strobes", 32'(strobes - s0), 32'd0);
    run_req("lh3", 1'b0, 3'b001, 32'd3, 32'h0, 32'h0, E_MIS, 1);
`endif

    // Reset during beat 1 of SH at 8: beat 0 stays written, beat 1 never lands
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b001; addr = 32'd8; wdata = 32'h0000_5566;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort.beat1_on_bus", mem_addr, 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("abort.mem_zero", 32'({mem_read, mem_write, mem_size}) | mem_addr | mem_wdata, 32'd0);
    chk("abort.ready", 32'(req_ready), 32'd1);
    chk("abort.resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort.no_resp", 32'(resp_valid), 32'd0);
    end
    chk("abort.mem8", 32'(mem[8]), 32'h66);
    chk("abort.mem9", 32'(mem[9]), 32'h00);

    run_req("post_abort_lhu8", 1'b0, 3'b101, 32'd8, 32'h0, 32'h0000_0066, E_NONE, 3);
    chk("no_rw_overlap", 32'(overlap), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
